// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, one-word imem read per instruction,
// registered instruction handed to decode over valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  logic        discard;
  logic [31:0] tgt;

  assign tgt         = redirect_pc & ~32'h3;
  assign mem_addr    = pc;
  assign instr_valid = (state == HOLD) && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC & ~32'h3;
      instruction <= '0;
      discard     <= 1'b0;
      mem_req     <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      unique case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
          if (redirect) pc <= tgt;
        end
        REQ: begin
          state <= WAIT;
          if (redirect) begin
            pc      <= tgt;
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            // a redirect landing on the response cycle drops it too
            if (discard || redirect) begin
              discard <= 1'b0;
              state   <= REQ;
              mem_req <= 1'b1;
              if (redirect) pc <= tgt;
            end else begin
              instruction <= mem_rdata;
              state       <= HOLD;
            end
          end else if (redirect) begin
            pc      <= tgt;
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc      <= tgt;
            state   <= REQ;
            mem_req <= 1'b1;
          end else if (instr_ready) begin
            pc      <= pc + 32'd4;
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: behavioural imem
// with variable latency and an architectural PC-flow model.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] maddr = '0;
  logic [31:0] next_pc;

  logic [31:0] xfer_pc[$];
  logic [31:0] xfer_ins[$];
  logic [31:0] req_addr[$];

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .pc(pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // distinct word per address; 0x100 holds addi x1,x0,5
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a - 32'h100) * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem_word(maddr);
        end
      end
      if (mem_req) begin
        cnt   = lat;
        maddr = mem_addr;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready) begin
        xfer_pc.push_back(pc);
        xfer_ins.push_back(instruction);
      end
      if (mem_req) req_addr.push_back(mem_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = instr_valid;
    for (int i = 0; i < budget; i++) begin
      if (ok) break;
      tick();
      ok = instr_valid;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_req got=%0b exp=0", mem_req);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b exp=0", instr_valid);
    end
    checks++;
    if (pc !== RPC || mem_addr !== RPC) begin
      failures++;
      $display("FAIL reset_pc got=%h/%h exp=%h", pc, mem_addr, RPC);
    end
    checks++;
    if (instruction !== 32'h0) begin
      failures++;
      $display("FAIL reset_instr got=%h exp=0", instruction);
    end
  endtask

  task automatic test_first_fetch;
    lat = 1;
    instr_ready = 1'b1;
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_req got=%0b exp=0", mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC) begin
      failures++;
      $display("FAIL first_req got=%0b@%h exp=1@%h",
               mem_req, mem_addr, RPC);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_wait req=%0b vld=%0b exp=0/0",
               mem_req, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h0050_0093 ||
        pc !== RPC) begin
      failures++;
      $display("FAIL first_instr vld=%0b ins=%h pc=%h exp=1/00500093/%h",
               instr_valid, instruction, pc, RPC);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
      failures++;
      $display("FAIL second_req got=%0b@%h exp=1@00000104",
               mem_req, mem_addr);
    end
  endtask

  task automatic test_stream;
    xfer_pc.delete();
    xfer_ins.delete();
    req_addr.delete();
    for (int c = 0; c < 300; c++) begin
      lat = $urandom_range(1, 4);
      instr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    instr_ready = 1'b0;
    checks++;
    if (xfer_pc.size() < 20) begin
      failures++;
      $display("FAIL stream_count got=%0d exp>=20", xfer_pc.size());
    end
    for (int i = 0; i < xfer_pc.size(); i++) begin
      checks++;
      if (xfer_pc[i] !== 32'h104 + 4 * i ||
          xfer_ins[i] !== mem_word(32'h104 + 4 * i)) begin
        failures++;
        $display("FAIL stream_xfer[%0d] got=%h/%h exp=%h/%h", i,
                 xfer_pc[i], xfer_ins[i], 32'h104 + 4 * i,
                 mem_word(32'h104 + 4 * i));
      end
    end
    for (int i = 0; i < req_addr.size(); i++) begin
      checks++;
      if (req_addr[i] !== 32'h104 + 4 * i) begin
        failures++;
        $display("FAIL stream_req[%0d] got=%h exp=%h", i,
                 req_addr[i], 32'h104 + 4 * i);
      end
    end
    checks++;
    if (req_addr.size() < xfer_pc.size() ||
        req_addr.size() > xfer_pc.size() + 1) begin
      failures++;
      $display("FAIL stream_reqs got=%0d exp=%0d..%0d", req_addr.size(),
               xfer_pc.size(), xfer_pc.size() + 1);
    end
    next_pc = 32'h104 + 32'(4 * xfer_pc.size());
  endtask

  task automatic test_hold_stall;
    bit ok;
    int n0;
    lat = 1;
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== next_pc || instruction !== mem_word(next_pc)) begin
      failures++;
      $display("FAIL stall_enter vld=%0b pc=%h ins=%h exp=1/%h/%h",
               ok, pc, instruction, next_pc, mem_word(next_pc));
    end
    n0 = xfer_pc.size();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || mem_req !== 1'b0 || pc !== next_pc ||
          instruction !== mem_word(next_pc)) begin
        failures++;
        $display("FAIL stall_hold[%0d] vld=%0b req=%0b pc=%h ins=%h",
                 c, instr_valid, mem_req, pc, instruction);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (xfer_pc.size() != n0 + 1) begin
      failures++;
      $display("FAIL stall_one_xfer got=%0d exp=%0d",
               xfer_pc.size() - n0, 1);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== next_pc + 32'd4) begin
      failures++;
      $display("FAIL stall_next got=%0b@%h exp=1@%h",
               mem_req, mem_addr, next_pc + 32'd4);
    end
    next_pc = next_pc + 32'd4;
  endtask

  task automatic test_redirect_hold;
    bit ok;
    int n0;
    wait_valid(20, ok);
    redirect_pc = 32'h10C;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10C) begin
      failures++;
      $display("FAIL rdh_pre got=%0b@%h exp=1@0000010c", mem_req, mem_addr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== 32'h10C) begin
      failures++;
      $display("FAIL rdh_hold vld=%0b pc=%h exp=1/0000010c", ok, pc);
    end
    n0 = xfer_pc.size();
    instr_ready = 1'b1;
    redirect_pc = 32'h200;
    redirect = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdh_gate vld=%0b exp=0", instr_valid);
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (xfer_pc.size() != n0) begin
      failures++;
      $display("FAIL rdh_noxfer got=%0d exp=0", xfer_pc.size() - n0);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL rdh_req got=%0b@%h exp=1@00000200", mem_req, mem_addr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== 32'h200 || instruction !== mem_word(32'h200)) begin
      failures++;
      $display("FAIL rdh_instr vld=%0b pc=%h ins=%h exp=1/00000200/%h",
               ok, pc, instruction, mem_word(32'h200));
    end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    bit seen;
    int n0;
    int w;
    lat = 4;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    tick();
    n0 = xfer_pc.size();
    redirect_pc = 32'h43;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    ok = 1'b0;
    seen = 1'b0;
    w = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        w = i;
        break;
      end
      if (instr_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (!ok || mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL rdw_req got=%0b@%h exp=1@00000040", ok, mem_addr);
    end
    checks++;
    if (w != 2) begin
      failures++;
      $display("FAIL rdw_delay got=%0d exp=2", w);
    end
    checks++;
    if (seen || xfer_pc.size() != n0) begin
      failures++;
      $display("FAIL rdw_dropped vld_seen=%0b xfers=%0d exp=0/0",
               seen, xfer_pc.size() - n0);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== 32'h40 || instruction !== mem_word(32'h40)) begin
      failures++;
      $display("FAIL rdw_instr vld=%0b pc=%h ins=%h exp=1/00000040/%h",
               ok, pc, instruction, mem_word(32'h40));
    end
  endtask

  task automatic test_wrap;
    bit ok;
    lat = 1;
    redirect_pc = 32'hFFFF_FFFE;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_req got=%0b@%h exp=1@fffffffc", mem_req, mem_addr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== 32'hFFFF_FFFC ||
        instruction !== mem_word(32'hFFFF_FFFC)) begin
      failures++;
      $display("FAIL wrap_hold vld=%0b pc=%h exp=1/fffffffc", ok, pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next got=%0b@%h exp=1@00000000", mem_req, mem_addr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== 32'h0 || instruction !== mem_word(32'h0)) begin
      failures++;
      $display("FAIL wrap_instr vld=%0b pc=%h ins=%h exp=1/0/%h",
               ok, pc, instruction, mem_word(32'h0));
    end
  endtask

  task automatic test_random_redirect;
    logic [31:0] exp;
    bit xf;
    int nx;
    exp = 32'h0;
    nx = 0;
    for (int c = 0; c < 400; c++) begin
      lat = $urandom_range(1, 4);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF
                                                 : 32'($urandom);
      @(negedge clk);
      if (mem_req) begin
        checks++;
        if (mem_addr !== exp) begin
          failures++;
          $display("FAIL rnd_req c=%0d got=%h exp=%h", c, mem_addr, exp);
        end
      end
      if (redirect) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_gate c=%0d vld=%0b exp=0", c, instr_valid);
        end
      end
      xf = instr_valid && instr_ready;
      if (xf) begin
        nx++;
        checks++;
        if (pc !== exp || instruction !== mem_word(exp)) begin
          failures++;
          $display("FAIL rnd_xfer c=%0d got=%h/%h exp=%h/%h", c,
                   pc, instruction, exp, mem_word(exp));
        end
      end
      if (redirect) exp = redirect_pc & ~32'h3;
      else if (xf) exp = exp + 32'd4;
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (nx < 10) begin
      failures++;
      $display("FAIL rnd_progress got=%0d exp>=10", nx);
    end
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    lat = 4;
    instr_ready = 1'b1;
    ok = mem_req;
    for (int i = 0; i < 20; i++) begin
      if (ok) break;
      tick();
      ok = mem_req;
    end
    instr_ready = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_find_req got=0 exp=1");
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== RPC ||
        mem_addr !== RPC || instruction !== 32'h0) begin
      failures++;
      $display("FAIL rst_async req=%0b vld=%0b pc=%h ins=%h exp=0/0/%h/0",
               mem_req, instr_valid, pc, instruction, RPC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got=%0b exp=0", mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC) begin
      failures++;
      $display("FAIL rst_restart got=%0b@%h exp=1@%h", mem_req, mem_addr, RPC);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || pc !== RPC || instruction !== 32'h0050_0093) begin
      failures++;
      $display("FAIL rst_instr vld=%0b pc=%h ins=%h exp=1/%h/00500093",
               ok, pc, instruction, RPC);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stream();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_wrap();
    test_random_redirect();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
